// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480@60 timing constants, bar colours and RGB332 expansion
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int BAR_WIDTH_DEF = 80;

    // Element 0 is the leftmost bar (white), element 7 the rightmost (black).
    localparam logic [7:0][7:0] BAR_COLOURS = {
        8'h00, 8'h03, 8'hE0, 8'hE3, 8'h1C, 8'h1F, 8'hFC, 8'hFF
    };

    function automatic logic [23:0] expand_rgb332(input logic [7:0] d);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = {d[7:5], d[7:5], d[7:6]};
        g = {d[4:2], d[4:2], d[4:3]};
        b = {d[1:0], d[1:0], d[1:0], d[1:0]};
        return {r, g, b};
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - pixel-enable divider, h/v counters and sync/visible decode
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    output logic             pix_en_o,
    output logic [CNT_W-1:0] hcnt_o,
    output logic [CNT_W-1:0] vcnt_o,
    output logic             visible_o,
    output logic             hsync_n_o,
    output logic             vsync_n_o
);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic             pix_en_q, pix_en_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;

    always_comb begin
        pix_en_d = ~pix_en_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        if (pix_en_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_en_q <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
        end else begin
            pix_en_q <= pix_en_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
        end
    end

    assign pix_en_o  = pix_en_q;
    assign hcnt_o    = hcnt_q;
    assign vcnt_o    = vcnt_q;
    assign visible_o = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    assign hsync_n_o = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
    assign vsync_n_o = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));

endmodule

// File: rtl/vga_test.sv
// rtl/vga_test.sv - VGA colour-bar test source: pattern lookup, RGB expansion, output registers
module vga_test
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int BAR_WIDTH = BAR_WIDTH_DEF
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    output logic       VGA_CLK,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic [7:0] memData
);

    logic             pix_en;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    logic             visible;
    logic             hsync_n;
    logic             vsync_n;

    vga_sync_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_sync (
        .clk_i     (CLOCK_50),
        .rst_ni    (RESET_N),
        .pix_en_o  (pix_en),
        .hcnt_o    (hcnt),
        .vcnt_o    (vcnt),
        .visible_o (visible),
        .hsync_n_o (hsync_n),
        .vsync_n_o (vsync_n)
    );

    logic [CNT_W-1:0] bar_div;
    logic [2:0]       bar_idx;
    logic [7:0]       mem_q, mem_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             hs_q, vs_q, blank_n_q;

    always_comb begin
        bar_div = hcnt / CNT_W'(BAR_WIDTH);
        bar_idx = (bar_div > CNT_W'(7)) ? 3'd7 : bar_div[2:0];
        mem_d   = 8'h00;
        rgb_d   = 24'h000000;
        if (visible) begin
            mem_d = BAR_COLOURS[bar_idx];
            rgb_d = expand_rgb332(mem_d);
        end
    end

    // Registers load only on pixel-enable edges, giving one pixel of latency
    // against the counters; VGA_CLK rises mid-pixel while the data is stable.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_q     <= 8'h00;
            rgb_q     <= 24'h000000;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else if (pix_en) begin
            mem_q     <= mem_d;
            rgb_q     <= rgb_d;
            hs_q      <= hsync_n;
            vs_q      <= vsync_n;
            blank_n_q <= visible;
        end
    end

    assign VGA_CLK     = pix_en;
    assign memData     = mem_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_test.sv
// tb/tb_vga_test.sv - self-checking bench for vga_test (full line timing, shortened frame)
`timescale 1ns/1ps
module tb_vga_test;

    localparam int HV = 640, HF = 16, HSW = 96, HB = 48, HT = 800;
    // Shortened vertical timing keeps two whole frames within a short run.
    localparam int VV = 8, VF = 2, VSW = 2, VB = 2, VT = 14;
    localparam int BW = 80;
    localparam logic [7:0] BARS [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic [7:0] VGA_R, VGA_G, VGA_B, memData;

    vga_test #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
        .BAR_WIDTH (BW)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .VGA_CLK     (VGA_CLK),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK_N (VGA_BLANK_N),
        .VGA_SYNC_N  (VGA_SYNC_N),
        .memData     (memData)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       vclk;
        logic [7:0] mem;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       hs;
        logic       vs;
        logic       blank;
    } exp_t;

    typedef struct packed {
        int         h;
        int         v;
        logic [7:0] mem;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       blank;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int edges = 0;
    logic chk_en = 1'b0;
    exp_t exp_s, got_s;

    // Outputs after the n-th rising edge since reset release, from the timing rules alone.
    function automatic exp_t model(input int n);
        exp_t e;
        int k, h, v;
        logic vis;
        e.vclk = (n % 2) == 1;
        if (n < 2) begin
            e.mem = 8'h00; e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
            e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b0;
            return e;
        end
        k   = n / 2 - 1;
        h   = k % HT;
        v   = (k / HT) % VT;
        vis = (h < HV) && (v < VV);
        e.mem   = vis ? BARS[h / BW] : 8'h00;
        e.r     = {e.mem[7:5], e.mem[7:5], e.mem[7:6]};
        e.g     = {e.mem[4:2], e.mem[4:2], e.mem[4:3]};
        e.b     = {e.mem[1:0], e.mem[1:0], e.mem[1:0], e.mem[1:0]};
        e.hs    = !((h >= HV + HF) && (h < HV + HF + HSW));
        e.vs    = !((v >= VV + VF) && (v < VV + VF + VSW));
        e.blank = vis;
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_s = model(edges);
            got_s = {VGA_CLK, memData, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N};
            checks++;
            if (got_s !== exp_s) begin
                errors++;
                $display("FAIL cycle edge=%0d got=%h want=%h", edges, got_s, exp_s);
            end
            checks++;
            if (VGA_SYNC_N !== 1'b0) begin
                errors++;
                $display("FAIL sync_n edge=%0d got=%b want=0", edges, VGA_SYNC_N);
            end
        end
    end

    int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    int blank_cnt = 0;
    realtime vclk_t0 = 0.0, vclk_t1 = 0.0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hs_prev && !VGA_HS) hs_fall.push_back(edges);
            if (!hs_prev && VGA_HS) hs_rise.push_back(edges);
            if (vs_prev && !VGA_VS) vs_fall.push_back(edges);
            if (!vs_prev && VGA_VS) vs_rise.push_back(edges);
            if (VGA_BLANK_N === 1'b1 && edges >= 2 && edges < 2 + 2 * VT * HT) blank_cnt++;
        end
        hs_prev = VGA_HS;
        vs_prev = VGA_VS;
    end

    always @(posedge VGA_CLK) begin
        vclk_t0 = vclk_t1;
        vclk_t1 = $realtime;
    end

    task automatic check_int(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_edges(input int target);
        int guard = 0;
        while (edges < target && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        check_int("wait_bound", longint'(edges >= target), 1);
    endtask

    task automatic check_reset_vals(input string name);
        check_int({name, "_mem"}, memData, 0);
        check_int({name, "_rgb"}, {VGA_R, VGA_G, VGA_B}, 0);
        check_int({name, "_hsvs"}, {VGA_HS, VGA_VS}, 2'b11);
        check_int({name, "_blank"}, VGA_BLANK_N, 0);
        check_int({name, "_vclk"}, VGA_CLK, 0);
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{h: 0,   v: 0, mem: 8'hFF, r: 8'hFF, g: 8'hFF, b: 8'hFF, blank: 1'b1};
        tbl[1]  = '{h: 79,  v: 0, mem: 8'hFF, r: 8'hFF, g: 8'hFF, b: 8'hFF, blank: 1'b1};
        tbl[2]  = '{h: 80,  v: 0, mem: 8'hFC, r: 8'hFF, g: 8'hFF, b: 8'h00, blank: 1'b1};
        tbl[3]  = '{h: 639, v: 0, mem: 8'h00, r: 8'h00, g: 8'h00, b: 8'h00, blank: 1'b1};
        tbl[4]  = '{h: 640, v: 0, mem: 8'h00, r: 8'h00, g: 8'h00, b: 8'h00, blank: 1'b0};
        tbl[5]  = '{h: 160, v: 1, mem: 8'h1F, r: 8'h00, g: 8'hFF, b: 8'hFF, blank: 1'b1};
        tbl[6]  = '{h: 240, v: 2, mem: 8'h1C, r: 8'h00, g: 8'hFF, b: 8'h00, blank: 1'b1};
        tbl[7]  = '{h: 320, v: 3, mem: 8'hE3, r: 8'hFF, g: 8'h00, b: 8'hFF, blank: 1'b1};
        tbl[8]  = '{h: 400, v: 4, mem: 8'hE0, r: 8'hFF, g: 8'h00, b: 8'h00, blank: 1'b1};
        tbl[9]  = '{h: 480, v: 5, mem: 8'h03, r: 8'h00, g: 8'h00, b: 8'hFF, blank: 1'b1};
        tbl[10] = '{h: 560, v: 6, mem: 8'h00, r: 8'h00, g: 8'h00, b: 8'h00, blank: 1'b1};
        tbl[11] = '{h: 0,   v: 8, mem: 8'h00, r: 8'h00, g: 8'h00, b: 8'h00, blank: 1'b0};

        #15 chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        #3 rst_n = 1'b1;
        wait_edges(2);
        check_int("first_pixel_mem", memData, 8'hFF);

        for (int i = 0; i < 12; i++) begin
            wait_edges(2 * (tbl[i].v * HT + tbl[i].h + 1));
            check_int($sformatf("vec%0d_mem", i), memData, tbl[i].mem);
            check_int($sformatf("vec%0d_rgb", i), {VGA_R, VGA_G, VGA_B},
                      {tbl[i].r, tbl[i].g, tbl[i].b});
            check_int($sformatf("vec%0d_blank", i), VGA_BLANK_N, tbl[i].blank);
        end

        wait_edges(2 * 2 * VT * HT + 3300 * 2);
        check_int("hs_fall_count", longint'(hs_fall.size() >= 2), 1);
        check_int("vs_fall_count", longint'(vs_fall.size() >= 2 && vs_rise.size() >= 1), 1);
        if (hs_fall.size() >= 2 && hs_rise.size() >= 1 && vs_fall.size() >= 2 && vs_rise.size() >= 1) begin
            check_int("hs_period_ns", (hs_fall[1] - hs_fall[0]) * 20, 32000);
            check_int("hs_low_ns", (hs_rise[0] - hs_fall[0]) * 20, 3840);
            check_int("vs_period_ns", longint'(vs_fall[1] - vs_fall[0]) * 20, VT * 32000);
            check_int("vs_low_ns", longint'(vs_rise[0] - vs_fall[0]) * 20, 64000);
        end
        check_int("vga_clk_period_ns", longint'(vclk_t1 - vclk_t0), 40);
        check_int("blank_high_cycles", blank_cnt, HV * VV * 2);

        repeat ($urandom_range(200, 1400)) @(posedge clk);
        #7 rst_n = 1'b0;
        #1 check_reset_vals("async_reset");
        hs_fall.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #($urandom_range(1, 8)) rst_n = 1'b1;
        wait_edges(1400);
        check_int("hs_fall_after_release", hs_fall.size() > 0 ? hs_fall[0] : -1, 2 * (656 + 1));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
